// File: rtl/age_fcfs_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | age_fcfs_arb_if : request vector and registered grant offer handshake       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface age_fcfs_arb_if #(
  parameter int NUM_REQ = 60,
  parameter int AGE_W   = 8
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic               gnt_ready;
  logic               gnt_valid;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic [AGE_W-1:0]   gnt_age;

  // master = arbiter side (offers grants), slave = requesters / allocator side
  modport master (
    input  req, gnt_ready,
    output gnt_valid, gnt, gnt_idx, gnt_age
  );

  modport slave (
    output req, gnt_ready,
    input  gnt_valid, gnt, gnt_idx, gnt_age
  );
endinterface
`default_nettype wire

// File: rtl/age_fcfs_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | age_fcfs_arb : oldest-first arbiter with saturating ages, registered grant |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module age_fcfs_arb #(
  parameter int NUM_REQ = 60,
  parameter int AGE_W   = 8,
  parameter int TIE_RR  = 1
) (
  input  wire logic            clk,
  input  wire logic            rst,
  age_fcfs_arb_if.master       bus_io
);
  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OFFER = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [AGE_W-1:0]   age_q [NUM_REQ];
  logic [AGE_W-1:0]   age_d [NUM_REQ];
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] gnt_q;
  logic [IDX_W-1:0]   gnt_idx_q;
  logic [AGE_W-1:0]   gnt_age_q;

  logic               w_accept;
  logic               w_held;
  logic [NUM_REQ-1:0] w_elig;
  logic               w_win_any;
  logic [IDX_W-1:0]   w_win_idx;
  logic [AGE_W:0]     w_win_key;
  logic [AGE_W:0]     w_key;
  logic               w_load;
  logic               w_clear;
  logic               w_adv_rr;

  assign w_accept = (state_q == S_OFFER) & bus_io.gnt_ready;
  assign w_held   = |(bus_io.req & gnt_q);
  assign w_elig   = bus_io.req & ~(w_accept ? gnt_q : '0);

  // Key = {age, at-or-after rr_ptr}; a strict-greater scan from index 0 then
  // yields the first tied index at/after rr_ptr, wrapping to the lowest one.
  always_comb begin
    w_win_any = 1'b0;
    w_win_idx = '0;
    w_win_key = '0;
    w_key     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_key = {age_q[i], (TIE_RR != 0) && (IDX_W'(i) >= rr_ptr_q)};
      if (w_elig[i] && (!w_win_any || (w_key > w_win_key))) begin
        w_win_any = 1'b1;
        w_win_idx = IDX_W'(i);
        w_win_key = w_key;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = w_win_any ? S_OFFER : S_IDLE;
      S_OFFER: begin
        if (w_accept)     state_d = w_win_any ? S_OFFER : S_IDLE;
        else if (!w_held) state_d = S_IDLE;
        else              state_d = S_OFFER;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_load   = 1'b0;
    w_clear  = 1'b0;
    w_adv_rr = 1'b0;
    unique case (state_q)
      S_IDLE:  w_load = w_win_any;
      S_OFFER: begin
        w_adv_rr = w_accept;
        w_load   = w_accept & w_win_any;
        w_clear  = (w_accept & ~w_win_any) | (~w_accept & ~w_held);
      end
      default: w_clear = 1'b1;
    endcase
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (w_adv_rr)
      rr_ptr_d = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((w_accept && gnt_q[i]) || !bus_io.req[i]) age_d[i] = '0;
      else if (age_q[i] != {AGE_W{1'b1}})           age_d[i] = age_q[i] + 1'b1;
      else                                          age_d[i] = age_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) age_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < NUM_REQ; i++) age_q[i] <= age_d[i];
    end
  end

  // The snapshot is the winner's age before this edge's increment.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      gnt_age_q <= '0;
    end else if (w_load) begin
      gnt_q     <= NUM_REQ'(1) << w_win_idx;
      gnt_idx_q <= w_win_idx;
      gnt_age_q <= age_q[w_win_idx];
    end
  end

  assign bus_io.gnt_valid = (state_q == S_OFFER);
  assign bus_io.gnt       = gnt_q;
  assign bus_io.gnt_idx   = gnt_idx_q;
  assign bus_io.gnt_age   = gnt_age_q;
endmodule
`default_nettype wire

// File: tb/tb_age_fcfs_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_age_fcfs_arb : round-robin and fixed-priority instances vs queue model  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_age_fcfs_arb;
  localparam int N    = 8;
  localparam int AW   = 4;
  localparam int AMAX = 15;

  typedef struct packed {
    logic       v;
    logic [7:0] g;
    logic [2:0] idx;
    logic [3:0] age;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_s = '0;
  logic       rdy_s = 1'b0;
  logic       started = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  age_fcfs_arb_if #(.NUM_REQ(N), .AGE_W(AW)) if_rr ();
  age_fcfs_arb_if #(.NUM_REQ(N), .AGE_W(AW)) if_lo ();

  assign if_rr.req       = req_s;
  assign if_rr.gnt_ready = rdy_s;
  assign if_lo.req       = req_s;
  assign if_lo.gnt_ready = rdy_s;

  age_fcfs_arb #(.NUM_REQ(N), .AGE_W(AW), .TIE_RR(1)) u_rr (
    .clk(clk), .rst(rst), .bus_io(if_rr.master));
  age_fcfs_arb #(.NUM_REQ(N), .AGE_W(AW), .TIE_RR(0)) u_lo (
    .clk(clk), .rst(rst), .bus_io(if_lo.master));

  logic       dv [2];
  logic [7:0] dg [2];
  logic [2:0] di [2];
  logic [3:0] da [2];
  assign dv[0] = if_rr.gnt_valid; assign dv[1] = if_lo.gnt_valid;
  assign dg[0] = if_rr.gnt;       assign dg[1] = if_lo.gnt;
  assign di[0] = if_rr.gnt_idx;   assign di[1] = if_lo.gnt_idx;
  assign da[0] = if_rr.gnt_age;   assign da[1] = if_lo.gnt_age;

  // Reference model: instance 0 = round-robin ties, instance 1 = lowest index
  int   m_age [2][N];
  bit   m_v   [2];
  int   m_idx [2];
  int   m_ag  [2];
  int   m_rr  [2];
  exp_t q0 [$];
  exp_t q1 [$];
  logic [7:0] acc_m;

  task automatic step(input int d);
    int w, mx, oi, j;
    bit acc, found;
    logic [7:0] el;
    exp_t e;
    if (rst) begin
      for (int i = 0; i < N; i++) m_age[d][i] = 0;
      m_rr[d] = 0; m_v[d] = 0; m_idx[d] = 0; m_ag[d] = 0;
    end else begin
      oi  = m_idx[d];
      acc = m_v[d] && rdy_s;
      el  = req_s;
      if (acc) el[oi] = 1'b0;
      mx = -1;
      for (int i = 0; i < N; i++)
        if (el[i] && m_age[d][i] > mx) mx = m_age[d][i];
      w = 0; found = 0;
      if (d == 0) begin
        for (int k = 0; k < N; k++) begin
          j = (m_rr[d] + k) % N;
          if (!found && el[j] && m_age[d][j] == mx) begin w = j; found = 1; end
        end
      end else begin
        for (int i = N - 1; i >= 0; i--)
          if (el[i] && m_age[d][i] == mx) w = i;
      end
      if (!m_v[d]) begin
        if (mx >= 0) begin m_v[d] = 1; m_idx[d] = w; m_ag[d] = m_age[d][w]; end
      end else if (acc) begin
        m_rr[d] = (oi + 1) % N;
        if (mx >= 0) begin m_idx[d] = w; m_ag[d] = m_age[d][w]; end
        else begin m_v[d] = 0; m_idx[d] = 0; m_ag[d] = 0; end
      end else if (!req_s[oi]) begin
        m_v[d] = 0; m_idx[d] = 0; m_ag[d] = 0;
      end
      for (int i = 0; i < N; i++) begin
        if ((acc && i == oi) || !req_s[i]) m_age[d][i] = 0;
        else if (m_age[d][i] < AMAX)       m_age[d][i] = m_age[d][i] + 1;
      end
    end
    e.v   = m_v[d];
    e.g   = m_v[d] ? 8'(1 << m_idx[d]) : 8'h00;
    e.idx = 3'(m_idx[d]);
    e.age = 4'(m_ag[d]);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic [7:0] rq, input logic rdy);
    @(negedge clk);
    rst   = r;
    req_s = rq;
    rdy_s = rdy;
    acc_m = (!r && m_v[0] && rdy) ? 8'(1 << m_idx[0]) : 8'h00;
    step(0);
    step(1);
    started = 1'b1;
  endtask

  task automatic cmp(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, d, $time, got, exp);
    end
  endtask

  // Monitor: one expected entry per DUT per clock, compared after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        for (int d = 0; d < 2; d++) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            checks++; errors++;
            $display("FAIL queue_empty dut%0d t=%0t: got 0 entries expected 1", d, $time);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            cmp("gnt_valid", d, 32'(dv[d]), 32'(e.v));
            cmp("gnt",       d, 32'(dg[d]), 32'(e.g));
            cmp("gnt_idx",   d, 32'(di[d]), 32'(e.idx));
            if (e.v) cmp("gnt_age", d, 32'(da[d]), 32'(e.age));
            cmp("onehot",     d, 32'($countones(dg[d]) <= 1), 32'd1);
            cmp("gnt_at_idx", d, 32'(!dv[d] || dg[d][di[d]]), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] r;
    logic [7:0] fcfs_tbl [10];
    fcfs_tbl = '{8'h20, 8'h20, 8'h24, 8'h24, 8'hA4, 8'hA4, 8'hA4, 8'h84, 8'h80, 8'h00};
    acc_m = '0;

    cyc(1, 8'h00, 0); cyc(1, 8'h00, 0);

    // Single request, drop at accept
    cyc(0, 8'h08, 1); cyc(0, 8'h08, 1); cyc(0, 8'h00, 1); cyc(0, 8'h00, 1);

    // FCFS ordering with stalled downstream
    cyc(1, 8'h00, 0);
    for (int c = 0; c < 10; c++) cyc(0, fcfs_tbl[c], c >= 6);

    // Back-to-back, each request dropped after its accept
    cyc(1, 8'h00, 0);
    r = 8'hFF;
    for (int c = 0; c < 11; c++) begin cyc(0, r, 1); r = r & ~acc_m; end

    // Tie-break after granting req5 alone
    cyc(1, 8'h00, 0);
    cyc(0, 8'h20, 1); cyc(0, 8'h20, 1);
    r = 8'h81;
    for (int c = 0; c < 5; c++) begin cyc(0, r, 1); r = r & ~acc_m; end

    // Saturation of a waiting requester
    cyc(1, 8'h00, 0);
    cyc(0, 8'h01, 0);
    for (int c = 0; c < 30; c++) cyc(0, 8'h03, 0);
    cyc(0, 8'h03, 1); cyc(0, 8'h02, 1); cyc(0, 8'h00, 1);

    // Illegal retraction, then reset mid-offer, then rr_ptr back at 0
    cyc(1, 8'h00, 0);
    cyc(0, 8'h01, 1); cyc(0, 8'h01, 1); cyc(0, 8'h00, 0);
    cyc(0, 8'h10, 0); cyc(0, 8'h10, 0); cyc(0, 8'h00, 0); cyc(0, 8'h00, 0);
    cyc(0, 8'h81, 1); r = 8'h81 & ~acc_m; cyc(0, r, 1); cyc(0, 8'h00, 1);
    cyc(0, 8'h02, 0); cyc(0, 8'h02, 0); cyc(0, 8'h02, 0);
    cyc(1, 8'h02, 0);
    cyc(0, 8'h81, 1); r = 8'h81 & ~acc_m; cyc(0, r, 1); cyc(0, 8'h00, 1);

    // Randomized traffic with sticky requests and occasional resets
    r = 8'h00;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (r[i] && acc_m[i])  r[i] = $urandom_range(0, 1) == 0;
        else if (r[i])         r[i] = $urandom_range(0, 31) != 0;
        else                   r[i] = $urandom_range(0, 3) == 0;
      end
      cyc($urandom_range(0, 199) == 0, r, $urandom_range(0, 3) != 0);
    end
    cyc(0, 8'h00, 1); cyc(0, 8'h00, 1);

    @(posedge clk);
    #2;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d/%0d entries expected 0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
